dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request accept and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I load/store funct3 size/sign code.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  requester accepts the response.
REQ-013 rsp_rdata  output  32  load result, sign- or zero-extended.
REQ-014 rsp_err  output  1  request was illegal, misaligned or out of range.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE drives req_ready=1; WAIT and RESP drive req_ready=0.
REQ-017 Accept occurs on a rising edge with req_valid=1 in IDLE; the responder latches we, addr, funct3 and wdata at that edge.
REQ-018 After accept, go to WAIT and count WAIT_CYCLES cycles, then go to RESP; if WAIT_CYCLES=0, go directly IDLE->RESP.
REQ-019 rsp_valid SHALL be 1 exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 RESP holds rsp_valid=1 with stable rsp_rdata and rsp_err until an edge with rsp_ready=1, then goes to IDLE.
REQ-021 A req_valid coinciding with the rsp_ready handshake is not accepted; it is accepted no earlier than the following edge in IDLE.
REQ-022 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; any other code sets rsp_err=1.
REQ-023 Misalignment (halfword with addr[0]=1, word with addr[1:0]!=0) sets rsp_err=1.
REQ-024 addr[31:2] >= DEPTH_WORDS sets rsp_err=1.
REQ-025 On error: no storage write, rsp_rdata=0.
REQ-026 A legal store commits on the WAIT->RESP (or IDLE->RESP) edge, writing only the byte lanes selected by addr[1:0] and size; the other bytes remain unchanged.
REQ-027 For stores, rsp_rdata=0.
REQ-028 For loads, the byte or halfword at addr[1:0] is shifted to bit 0; LB/LH sign-extend and LBU/LHU zero-extend.
REQ-029 A load issued after a completed store to the same word returns the updated data.

Reset
REQ-030 While reset=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter=0.
REQ-031 Reset asserted in WAIT discards the pending request; an uncommitted store never writes.
REQ-032 Storage array contents are not reset and are undefined until written.

Structure
REQ-033 The shared riscv_pkg holds the funct3 load/store constants and the responder state enum.
REQ-034 Byte-lane alignment (write-enable and write-data generation, load extraction and extension) is placed in one combinational sub-module, lsu_align.
REQ-035 Storage is a DEPTH_WORDS x 32 array with per-byte write enables.

Verification (DEPTH_WORDS=256, WAIT_CYCLES=2)
REQ-036 SW 0x10=0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 3 cycles after each accept.
REQ-037 SB 0x13=0x80, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80ADBEEF.
REQ-038 LH 0x11 -> err 1, rdata 0; SW 0x12=0xFFFFFFFF -> err 1, then LW 0x10 still returns 0x80ADBEEF; funct3=011 -> err 1.
REQ-039 LW 0x400 -> err 1; a load with funct3=110 -> err 1.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, data stable, req_ready 0; with req_valid held high, the next request is accepted only after the handshake.
REQ-041 SW 0x20=0, then accept SW 0x20=0x12345678, then pull reset low during WAIT -> rsp_valid 0 and req_ready 1 after release; LW 0x20 -> 0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, access sizes and the
// data-memory responder state encoding.
package riscv_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } rsp_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } lsu_size_e;

    // Access size for a load/store funct3; SZ_BAD marks an unsupported code.
    function automatic lsu_size_e decode_size(input logic we, input logic [2:0] funct3);
        lsu_size_e size;
        size = SZ_BAD;
        if (we) begin
            case (funct3)
                F3_SB:   size = SZ_BYTE;
                F3_SH:   size = SZ_HALF;
                F3_SW:   size = SZ_WORD;
                default: size = SZ_BAD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size = SZ_BYTE;
                F3_LH, F3_LHU: size = SZ_HALF;
                F3_LW:         size = SZ_WORD;
                default:       size = SZ_BAD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for loads and stores: legality/misalignment check,
// store byte enables and replicated write data, load extraction and extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic        align_err,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    lsu_size_e   size;
    logic [31:0] shifted;

    assign size    = decode_size(we, funct3);
    assign shifted = rdata_word >> {addr_lo, 3'b000};

    // Illegal code or an address not aligned to the access size
    always_comb begin
        align_err = 1'b0;
        case (size)
            SZ_HALF: align_err = addr_lo[0];
            SZ_WORD: align_err = (addr_lo != 2'b00);
            SZ_BAD:  align_err = 1'b1;
            default: align_err = 1'b0;
        endcase
    end

    // Lanes touched by the store; nothing is enabled for a faulting access
    always_comb begin
        byte_en = 4'b0000;
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << addr_lo;
            SZ_HALF: byte_en = 4'b0011 << {addr_lo[1], 1'b0};
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        if (align_err) begin
            byte_en = 4'b0000;
        end
    end

    // Replicate right-aligned store data so every enabled lane sees its byte
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata_lane[8*gi +: 8] = (size == SZ_BYTE) ? wdata[7:0] :
                                       (size == SZ_HALF) ? wdata[8*(gi%2) +: 8] :
                                                           wdata[8*gi +: 8];
    end

    // Shift the addressed byte/halfword down to bit 0 and extend it
    always_comb begin
        load_data = 32'h0;
        case (size)
            SZ_BYTE: load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = funct3[2] ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_data = rdata_word;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then commits/reads the byte-lane storage and holds the
// response until the requester takes it.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    rsp_state_e  state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;

    logic        accept;
    logic        commit;
    logic        mem_wr;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [2:0]  sel_funct3;
    logic [31:0] sel_wdata;

    logic        range_err;
    logic        align_err;
    logic        err_total;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic [31:0] load_data;
    logic [31:0] rd_word;
    logic [IDX_W-1:0] mem_idx;

    // With zero wait states the commit happens on the accept edge itself, so
    // the live request is used in IDLE and the latched copy everywhere else.
    assign sel_we     = (state_reg == RSP_IDLE) ? req_we     : we_reg;
    assign sel_addr   = (state_reg == RSP_IDLE) ? req_addr   : addr_reg;
    assign sel_funct3 = (state_reg == RSP_IDLE) ? req_funct3 : funct3_reg;
    assign sel_wdata  = (state_reg == RSP_IDLE) ? req_wdata  : wdata_reg;

    assign range_err = (sel_addr[31:2] >= DEPTH_LIM);
    assign err_total = range_err | align_err;
    assign mem_idx   = sel_addr[IDX_W+1:2];

    lsu_align u_align (
        .we         (sel_we),
        .funct3     (sel_funct3),
        .addr_lo    (sel_addr[1:0]),
        .wdata      (sel_wdata),
        .rdata_word (rd_word),
        .align_err  (align_err),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    // Next-state, wait counting and handshake outputs
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        commit        = 1'b0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        case (state_reg)
            RSP_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept        = 1'b1;
                    wait_cnt_next = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        commit     = 1'b1;
                        state_next = RSP_RESP;
                    end else begin
                        state_next = RSP_WAIT;
                    end
                end
            end
            RSP_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    commit        = 1'b1;
                    wait_cnt_next = 4'd0;
                    state_next    = RSP_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            RSP_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = RSP_IDLE;
                end
            end
            default: begin
                state_next    = RSP_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // State, counter, request latch and response error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RSP_IDLE;
            wait_cnt_reg <= 4'd0;
            we_reg       <= 1'b0;
            addr_reg     <= 32'h0;
            funct3_reg   <= 3'b000;
            wdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                we_reg     <= req_we;
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                wdata_reg  <= req_wdata;
            end
            if (commit) begin
                err_reg <= err_total;
            end
        end
    end

    // Reset must block a commit even though storage itself is never reset
    assign mem_wr = commit & reset & sel_we & ~err_total;

    // One byte-wide RAM per lane: per-lane write enable, registered read
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rd_byte_reg;

        // Write the enabled lane and capture the word read at commit time
        always_ff @(posedge clk) begin
            if (mem_wr && byte_en[gi]) begin
                lane_mem[mem_idx] <= wdata_lane[8*gi +: 8];
            end
            if (commit) begin
                rd_byte_reg <= lane_mem[mem_idx];
            end
        end

        assign rd_word[8*gi +: 8] = rd_byte_reg;
    end

    // Load data only for a legal load; stores and faults return zero
    assign rsp_rdata = ((state_reg == RSP_RESP) && !err_reg && !we_reg) ? load_data : 32'h0;
    assign rsp_err   = (state_reg == RSP_RESP) & err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed load/store cases,
// back-pressure, reset during a pending store, and randomized traffic
// against a byte-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAIT_CYC = 2;
    localparam int LAT = WAIT_CYC + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [0:4*DEPTH-1];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAIT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        logic legal;
        int   nbytes;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        nbytes = 1 << f3[1:0];
        if ((addr % 32'(nbytes)) != 32'd0) return 1'b1;
        if (addr >= 32'(4*DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [2:0] f3);
        int          n;
        logic [31:0] v;
        logic [31:0] mask;
        n = 1 << f3[1:0];
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(addr) + i]) << (8*i));
        if (n < 4) begin
            mask = (32'd1 << (8*n)) - 32'd1;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) mdl[int'(addr) + i] = wd[8*i +: 8];
    endtask

    // ---------------- transaction driver ----------------
    task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er,
                             output int lat, output logic ok);
        int guard;
        ok = 1'b1; lat = 0; rd = 32'h0; er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        rsp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin ok = 1'b0; return; end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        $display("TXN we=%0d addr=%h f3=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, addr, f3, wd, rd, er, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2; req_wdata = 32'h0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_state got ready=%b valid=%b err=%b rdata=%h want ready=1 valid=0 err=0 rdata=0",
                         req_ready, rsp_valid, rsp_err, rsp_rdata);
            end
        end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } dir_t;

    task automatic test_directed;
        dir_t        tbl [23];
        logic [31:0] rd;
        logic        er, ok;
        int          lat;
        tbl[0]  = '{1'b1, 32'h10,  3'd2, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h13,  3'd0, 32'h00000080, 32'h00000000, 1'b0};
        tbl[3]  = '{1'b0, 32'h13,  3'd0, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1'b0, 32'h13,  3'd4, 32'h0,        32'h00000080, 1'b0};
        tbl[5]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[6]  = '{1'b0, 32'h11,  3'd1, 32'h0,        32'h00000000, 1'b1};
        tbl[7]  = '{1'b1, 32'h12,  3'd2, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[8]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[9]  = '{1'b0, 32'h10,  3'd3, 32'h0,        32'h00000000, 1'b1};
        tbl[10] = '{1'b1, 32'h10,  3'd3, 32'h00000001, 32'h00000000, 1'b1};
        tbl[11] = '{1'b0, 32'h400, 3'd2, 32'h0,        32'h00000000, 1'b1};
        tbl[12] = '{1'b0, 32'h10,  3'd6, 32'h0,        32'h00000000, 1'b1};
        tbl[13] = '{1'b0, 32'h12,  3'd1, 32'h0,        32'hFFFF80AD, 1'b0};
        tbl[14] = '{1'b0, 32'h12,  3'd5, 32'h0,        32'h000080AD, 1'b0};
        tbl[15] = '{1'b1, 32'h10,  3'd1, 32'hABCD1234, 32'h00000000, 1'b0};
        tbl[16] = '{1'b1, 32'h11,  3'd0, 32'hFFFFFF55, 32'h00000000, 1'b0};
        tbl[17] = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h80AD5534, 1'b0};
        tbl[18] = '{1'b1, 32'h10,  3'd4, 32'h11111111, 32'h00000000, 1'b1};
        tbl[19] = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h80AD5534, 1'b0};
        tbl[20] = '{1'b0, 32'h13,  3'd1, 32'h0,        32'h00000000, 1'b1};
        tbl[21] = '{1'b1, 32'h3FC, 3'd2, 32'hCAFEF00D, 32'h00000000, 1'b0};
        tbl[22] = '{1'b0, 32'h3FC, 3'd2, 32'h0,        32'hCAFEF00D, 1'b0};
        for (int k = 0; k < 23; k++) begin
            drive_txn(tbl[k].we, tbl[k].addr, tbl[k].f3, tbl[k].wd, rd, er, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL dir%0d_timeout got no handshake want response within 50 cycles", k);
            end else begin
                checks++;
                if (lat != LAT) begin
                    errors++;
                    $display("FAIL dir%0d_latency got %0d want %0d", k, lat, LAT);
                end
                checks++;
                if (er !== tbl[k].er) begin
                    errors++;
                    $display("FAIL dir%0d_err got %b want %b", k, er, tbl[k].er);
                end
                checks++;
                if (rd !== tbl[k].rd) begin
                    errors++;
                    $display("FAIL dir%0d_rdata got %h want %h", k, rd, tbl[k].rd);
                end
            end
            if (tbl[k].we && !tbl[k].er) model_store(tbl[k].addr, tbl[k].f3, tbl[k].wd);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] first_exp, second_exp;
        int          lat;
        first_exp  = exp_load(32'h10, 3'd2);
        second_exp = exp_load(32'h13, 3'd4);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Second request presented immediately and held
        req_addr = 32'h13; req_funct3 = 3'd4;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL bp_latency got %0d want %0d", lat, LAT);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== first_exp || req_ready !== 1'b0 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b err=%b want valid=1 rdata=%h ready=0 err=0",
                         c, rsp_valid, rsp_rdata, req_ready, rsp_err, first_exp);
            end
            @(negedge clk);
        end
        $display("TXN backpressure hold rdata=%h", rsp_rdata);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_accept_on_handshake got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept got ready=%b want 0", req_ready);
        end
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        checks++;
        if (lat != LAT || rsp_rdata !== second_exp || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_rsp got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=0",
                     lat, rsp_rdata, rsp_err, LAT, second_exp);
        end
        $display("TXN backpressure second rdata=%h lat=%0d", rsp_rdata, lat);
        @(posedge clk);
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd;
        logic        er, ok;
        int          lat;
        drive_txn(1'b1, 32'h20, 3'd2, 32'h0, rd, er, lat, ok);
        checks++;
        if (!ok || er !== 1'b0) begin
            errors++;
            $display("FAIL rw_clear_store got ok=%b err=%b want ok=1 err=0", ok, er);
        end
        model_store(32'h20, 3'd2, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'd2; req_wdata = 32'h12345678;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rw_during_reset got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rw_after_release%0d got valid=%b ready=%b want valid=0 ready=1",
                         c, rsp_valid, req_ready);
            end
        end
        drive_txn(1'b0, 32'h20, 3'd2, 32'h0, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== 32'h00000000 || er !== 1'b0) begin
            errors++;
            $display("FAIL rw_load_after got ok=%b rdata=%h err=%b want ok=1 rdata=00000000 err=0", ok, rd, er);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, addr, wd, exp_rd;
        logic        er, ok, we, exp_e;
        logic [2:0]  f3;
        int          lat;
        // Fill a 16-word window so every random load reads defined data
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            drive_txn(1'b1, 32'h40 + 32'(4*w), 3'd2, wd, rd, er, lat, ok);
            checks++;
            if (!ok || er !== 1'b0) begin
                errors++;
                $display("FAIL rnd_fill%0d got ok=%b err=%b want ok=1 err=0", w, ok, er);
            end
            model_store(32'h40 + 32'(4*w), 3'd2, wd);
        end
        for (int k = 0; k < 80; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) addr = 32'h400 + 32'($urandom_range(0, 4095));
            else                           addr = 32'h40 + 32'($urandom_range(0, 63));
            exp_e  = exp_err(we, addr, f3);
            exp_rd = (exp_e || we) ? 32'h0 : exp_load(addr, f3);
            drive_txn(we, addr, f3, wd, rd, er, lat, ok);
            checks++;
            if (!ok || lat != LAT || er !== exp_e || rd !== exp_rd) begin
                errors++;
                $display("FAIL rnd%0d we=%0d addr=%h f3=%0d got ok=%b lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         k, we, addr, f3, ok, lat, er, rd, LAT, exp_e, exp_rd);
            end
            if (we && !exp_e) model_store(addr, f3, wd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got simulation still running want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
